alu_scheduler: RTL and testbench

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_scheduler_pkg.sv | 33 +++
 rtl/alu_scheduler_alu.sv | 65 ++++++
 rtl/alu_scheduler.sv | 133 +++++++++++++
 tb/tb_alu_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the two-requester ALU scheduler: default operand
// width, opcode space, FSM state encoding and requester id type.
package alu_scheduler_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned OPCODE_W      = 4;
  localparam int unsigned NUM_OPCODES   = 12;

  // Opcodes at or above this value are rejected with rsp_err.
  localparam logic [OPCODE_W-1:0] FIRST_ILLEGAL_OP = OPCODE_W'(NUM_OPCODES);

  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'd0;   // out=a+b+cin, extra=carry
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'd1;   // out=a-b-cin, extra=borrow
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 4'd5;   // out=~a
  localparam logic [OPCODE_W-1:0] OP_SHL1 = 4'd6;   // shift in cin, extra=msb out
  localparam logic [OPCODE_W-1:0] OP_SHR1 = 4'd7;   // shift in cin, extra=lsb out
  localparam logic [OPCODE_W-1:0] OP_MUL  = 4'd8;   // {extra,out}=a*b
  localparam logic [OPCODE_W-1:0] OP_SLT  = 4'd9;   // out=signed a<b, extra=unsigned a<b
  localparam logic [OPCODE_W-1:0] OP_NREV = 4'd10;  // nibble order reversed
  localparam logic [OPCODE_W-1:0] OP_MAX  = 4'd11;  // out=max, extra=min (unsigned)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/alu_scheduler_alu.sv
// Combinational ALU shared by both requesters.
// Ports: opcode/a/b/carryin in; out_c/extra_c combinational results.
// Illegal opcodes produce zero here; the scheduler flags them separately.
module alu_scheduler_alu
  import alu_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                carryin,
  output logic [WIDTH-1:0]    out_c,
  output logic [WIDTH-1:0]    extra_c
);

  localparam int unsigned EW      = WIDTH + 1;
  localparam int unsigned PW      = 2 * WIDTH;
  localparam int unsigned NIBBLES = WIDTH / 4;

  logic [EW-1:0]    sum_ext;
  logic [EW-1:0]    diff_ext;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] nib_rev;

  assign sum_ext  = {1'b0, a} + {1'b0, b} + EW'(carryin);
  assign diff_ext = {1'b0, a} - {1'b0, b} - EW'(carryin);
  assign prod     = PW'(a) * PW'(b);

  // Nibble i of the result is nibble (NIBBLES-1-i) of a.
  always_comb begin
    nib_rev = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      nib_rev[4*i +: 4] = a[4*(NIBBLES-1-i) +: 4];
    end
  end

  // Operation select.
  always_comb begin
    out_c   = '0;
    extra_c = '0;
    case (opcode)
      OP_ADD:  begin out_c = sum_ext[WIDTH-1:0];  extra_c = WIDTH'(sum_ext[WIDTH]);  end
      OP_SUB:  begin out_c = diff_ext[WIDTH-1:0]; extra_c = WIDTH'(diff_ext[WIDTH]); end
      OP_AND:  out_c = a & b;
      OP_OR:   out_c = a | b;
      OP_XOR:  out_c = a ^ b;
      OP_NOT:  out_c = ~a;
      OP_SHL1: begin out_c = {a[WIDTH-2:0], carryin}; extra_c = WIDTH'(a[WIDTH-1]); end
      OP_SHR1: begin out_c = {carryin, a[WIDTH-1:1]}; extra_c = WIDTH'(a[0]);       end
      OP_MUL:  begin out_c = prod[WIDTH-1:0]; extra_c = prod[PW-1:WIDTH]; end
      OP_SLT:  begin
        out_c   = WIDTH'($signed(a) < $signed(b));
        extra_c = WIDTH'(a < b);
      end
      OP_NREV: out_c = nib_rev;
      OP_MAX:  begin
        out_c   = (a > b) ? a : b;
        extra_c = (a > b) ? b : a;
      end
      default: begin out_c = '0; extra_c = '0; end
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// Two-requester round-robin scheduler in front of a single ALU.
// One operation in flight: IDLE (grant) -> EXEC (compute) -> RESP (hold
// result until rsp_ready).
// Ports: clk, rst_n (sync, active-low); req0_*/req1_* valid/ready/opcode/
// a/b/carryin; rsp_valid/rsp_ready/rsp_out/rsp_extra/rsp_id/rsp_err; busy.
// reqN_ready is combinational; all rsp_* and busy are registered.
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OPCODE_W-1:0] req0_opcode,
  input  logic [WIDTH-1:0]    req0_a,
  input  logic [WIDTH-1:0]    req0_b,
  input  logic                req0_carryin,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OPCODE_W-1:0] req1_opcode,
  input  logic [WIDTH-1:0]    req1_a,
  input  logic [WIDTH-1:0]    req1_b,
  input  logic                req1_carryin,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_out,
  output logic [WIDTH-1:0]    rsp_extra,
  output logic                rsp_id,
  output logic                rsp_err,
  output logic                busy
);

  state_t  state, state_nx;
  req_id_t rr_ptr;
  req_id_t grant_id_c;
  logic    grant_c;

  logic [OPCODE_W-1:0] op_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic                cin_q;
  req_id_t             id_q;

  logic [WIDTH-1:0] alu_out_c, alu_extra_c;
  logic             illegal_c;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state and grant; ready is gated by rst_n so nothing is accepted in reset.
  always_comb begin
    state_nx   = state;
    grant_c    = 1'b0;
    grant_id_c = rr_ptr;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          grant_c = 1'b1;
          if (req0_valid && req1_valid) grant_id_c = rr_ptr;
          else                          grant_id_c = req1_valid;
          req0_ready = ~grant_id_c;
          req1_ready = grant_id_c;
          state_nx   = ST_EXEC;
        end
      end
      ST_EXEC: state_nx = ST_RESP;
      ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Round-robin pointer flips to the other requester after every grant.
  always_ff @(posedge clk) begin
    if (!rst_n)       rr_ptr <= 1'b0;
    else if (grant_c) rr_ptr <= ~grant_id_c;
  end

  // Capture the granted request; the ALU only ever sees these registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      id_q  <= 1'b0;
    end else if (grant_c) begin
      op_q  <= grant_id_c ? req1_opcode  : req0_opcode;
      a_q   <= grant_id_c ? req1_a       : req0_a;
      b_q   <= grant_id_c ? req1_b       : req0_b;
      cin_q <= grant_id_c ? req1_carryin : req0_carryin;
      id_q  <= grant_id_c;
    end
  end

  alu_scheduler_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode  (op_q),
    .a       (a_q),
    .b       (b_q),
    .carryin (cin_q),
    .out_c   (alu_out_c),
    .extra_c (alu_extra_c)
  );

  assign illegal_c = (op_q >= FIRST_ILLEGAL_OP);

  // Response registers: loaded once at the end of EXEC, held through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_extra <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= (state_nx == ST_RESP);
      busy      <= (state_nx != ST_IDLE);
      if (state == ST_EXEC) begin
        rsp_out   <= illegal_c ? '0 : alu_out_c;
        rsp_extra <= illegal_c ? '0 : alu_extra_c;
        rsp_id    <= id_q;
        rsp_err   <= illegal_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: transaction-level reference model,
// per-cycle compare on the falling edge, directed scenarios plus random traffic.
module tb_alu_scheduler;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [3:0]    req0_opcode = '0, req1_opcode = '0;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          req0_carryin = 1'b0, req1_carryin = 1'b0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [W-1:0]  rsp_out, rsp_extra;
  logic          rsp_id, rsp_err, busy;

  always #5 clk = ~clk;

  alu_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_carryin(req0_carryin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_carryin(req1_carryin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_extra(rsp_extra), .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU in plain 64-bit arithmetic.
  function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic cin,
                                  output logic [31:0] o, output logic [31:0] e,
                                  output logic err);
    longint unsigned la, lb, lc, s;
    la = 64'(a); lb = 64'(b); lc = 64'(cin);
    o = '0; e = '0; err = 1'b0;
    case (op)
      4'd0:  begin s = la + lb + lc; o = s[31:0]; e = 32'(s[32]); end
      4'd1:  begin s = la - lb - lc; o = s[31:0]; e = (la < lb + lc) ? 32'd1 : 32'd0; end
      4'd2:  o = a & b;
      4'd3:  o = a | b;
      4'd4:  o = a ^ b;
      4'd5:  o = ~a;
      4'd6:  begin s = la * 2 + lc; o = s[31:0]; e = 32'(la >> 31); end
      4'd7:  begin o = 32'((lc << 31) | (la >> 1)); e = 32'(la & 64'd1); end
      4'd8:  begin s = la * lb; o = s[31:0]; e = s[63:32]; end
      4'd9:  begin o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e = (a < b) ? 32'd1 : 32'd0; end
      4'd10: for (int i = 0; i < 8; i++) o = (o << 4) | ((a >> (4 * i)) & 32'hF);
      4'd11: begin o = (a > b) ? a : b; e = (a > b) ? b : a; end
      default: err = 1'b1;
    endcase
  endfunction

  // Transaction-level model: at most one op outstanding, aged in cycles since issue.
  bit          m_known = 0;
  bit          m_busy  = 0;
  bit          m_fresh = 0;   // since reset, no result latched yet
  int          m_age   = 0;
  bit          m_ptr   = 0;
  logic [31:0] m_out, m_extra;
  logic        m_err, m_id;
  int          cyc = 0;
  int          last_grant = -1;
  int          grant_log[$];
  int          grant_cyc[$];

  function automatic int exp_grant();
    if (!m_known || m_busy || !rst_n) return -1;
    if (req0_valid && req1_valid) return int'(m_ptr);
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    cyc++;
    last_grant = -1;
    if (!rst_n) begin
      m_known = 1; m_busy = 0; m_ptr = 0; m_fresh = 1;
    end else if (m_known) begin
      if (m_busy) begin
        if (m_age >= 2 && rsp_ready) m_busy = 0;
        else begin
          m_age++;
          if (m_age == 2) m_fresh = 0;
        end
      end else begin
        g = exp_grant();
        if (g >= 0) begin
          last_grant = g;
          m_ptr = (g == 0);
          if (g == 0) alu_ref(req0_opcode, req0_a, req0_b, req0_carryin, m_out, m_extra, m_err);
          else        alu_ref(req1_opcode, req1_a, req1_b, req1_carryin, m_out, m_extra, m_err);
          m_id = g[0];
          m_busy = 1; m_age = 1;
          grant_log.push_back(g);
          grant_cyc.push_back(cyc);
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    int g;
    if (m_known) begin
      g = exp_grant();
      chk("req0_ready", req0_ready, g == 0);
      chk("req1_ready", req1_ready, g == 1);
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, m_busy && m_age >= 2);
      if (m_busy && m_age >= 2) begin
        chk("rsp_out", rsp_out, m_out);
        chk("rsp_extra", rsp_extra, m_extra);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_err", rsp_err, m_err);
      end else if (m_fresh) begin
        chk("reset_out", rsp_out, 0);
        chk("reset_extra", rsp_extra, 0);
        chk("reset_id", rsp_id, 0);
        chk("reset_err", rsp_err, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; rsp_ready = 0; rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
  endtask

  task automatic issue(input int id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic cin);
    bit got = 0;
    if (id == 0) begin
      req0_valid = 1; req0_opcode = op; req0_a = a; req0_b = b; req0_carryin = cin;
    end else begin
      req1_valid = 1; req1_opcode = op; req1_a = a; req1_b = b; req1_carryin = cin;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (last_grant == id) got = 1;
    end
    chk("grant_wait", got, 1);
    if (id == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_idle();
    bit idle = 0;
    rsp_ready = 1;
    for (int i = 0; i < 20 && !idle; i++) begin
      if (!busy) idle = 1; else tick();
    end
    chk("idle_wait", idle, 1);
  endtask

  task automatic rand_req(input int id);
    logic [3:0]  op = 4'($urandom_range(0, 15));
    logic [31:0] a  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
    logic [31:0] b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
    logic        c  = 1'($urandom_range(0, 1));
    logic        v  = 1'($urandom_range(0, 1));
    if (id == 0) begin
      req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b; req0_carryin = c;
    end else begin
      req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b; req1_carryin = c;
    end
  endtask

  initial begin
    logic [31:0] eo, ee;
    logic        er;
    int          base;
    bit          ok;

    // Reset state.
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_out", rsp_out, 0);
    chk("rst_id", rsp_id, 0);

    // Single request: 2-cycle latency, literal result.
    rsp_ready = 1;
    issue(0, 4'd0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    chk("t029_valid_exec", rsp_valid, 0);
    tick();
    chk("t029_valid", rsp_valid, 1);
    chk("t029_out", rsp_out, 32'hFFFF_FFFF);
    chk("t029_extra", rsp_extra, 0);
    chk("t029_id", rsp_id, 0);
    tick();
    chk("t029_valid_drop", rsp_valid, 0);

    // Both requesters from reset: grants alternate 0,1,0,1 every 3 cycles.
    do_reset();
    rsp_ready = 1;
    base = grant_log.size();
    rand_req(0); rand_req(1);
    req0_valid = 1; req1_valid = 1; req0_opcode = 4'd2; req1_opcode = 4'd3;
    for (int i = 0; i < 40 && grant_log.size() < base + 4; i++) begin
      tick();
      if (last_grant == 0) begin req0_a = $urandom(); req0_opcode = 4'd0; end
      if (last_grant == 1) begin req1_b = $urandom(); req1_opcode = 4'd8; end
    end
    req0_valid = 0; req1_valid = 0;
    chk("t030_count", grant_log.size() - base, 4);
    if (grant_log.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) chk("t030_order", grant_log[base + i], i % 2);
      for (int i = 1; i < 4; i++)
        chk("t030_interval", grant_cyc[base + i] - grant_cyc[base + i - 1], 3);
    end

    // Back-pressure: outputs hold for 5 cycles, no new grant.
    wait_idle();
    rsp_ready = 0;
    issue(1, 4'd8, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    alu_ref(4'd8, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, eo, ee, er);
    req0_valid = 1; req1_valid = 1; req0_opcode = 4'd4; req1_opcode = 4'd5;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t031_valid", rsp_valid, 1);
      chk("t031_out", rsp_out, eo);
      chk("t031_extra", rsp_extra, ee);
      chk("t031_ready0", req0_ready, 0);
      chk("t031_ready1", req1_ready, 0);
      tick();
    end
    rsp_ready = 1;
    tick();
    chk("t031_fall", rsp_valid, 0);
    req0_valid = 0; req1_valid = 0;
    wait_idle();

    // Illegal opcode then a legal one.
    issue(1, 4'd13, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
    tick();
    chk("t032_err", rsp_err, 1);
    chk("t032_out", rsp_out, 0);
    chk("t032_extra", rsp_extra, 0);
    chk("t032_id", rsp_id, 1);
    tick();
    issue(0, 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
    tick();
    chk("t032_clear", rsp_err, 0);
    chk("t032_xor", rsp_out, 32'h0FF0_0FF0);

    // Reset while executing: no stale response, pointer back to 0.
    wait_idle();
    issue(0, 4'd0, 32'h1, 32'h2, 1'b0);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("t033_valid", rsp_valid, 0);
    chk("t033_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin tick(); chk("t033_stale", rsp_valid, 0); end
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("t033_ptr0", req0_ready, 1);
    chk("t033_ptr1", req1_ready, 0);
    tick();
    req0_valid = 0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); if (last_grant == 1) ok = 1; end
    chk("t033_req1_served", ok, 1);
    req1_valid = 0;

    // Opcode sweep with literal pins on a few results.
    for (int op = 0; op < 12; op++) begin
      wait_idle();
      issue(0, 4'(op), 32'h6666_6666, 32'h6666_6666, 1'b1);
      tick();
      alu_ref(4'(op), 32'h6666_6666, 32'h6666_6666, 1'b1, eo, ee, er);
      chk("t034_out", rsp_out, eo);
      chk("t034_extra", rsp_extra, ee);
      if (op == 0) chk("t034_add_lit", rsp_out, 32'hCCCC_CCCD);
      if (op == 1) chk("t034_sub_lit", {rsp_extra, rsp_out}, 64'h1_FFFF_FFFF);
      if (op == 5) chk("t034_not_lit", rsp_out, 32'h9999_9999);
    end
    wait_idle();
    issue(1, 4'd10, 32'h1234_5678, 32'h0, 1'b0);
    tick();
    chk("nrev_lit", rsp_out, 32'h8765_4321);

    // Random traffic with back-pressure and occasional resets.
    wait_idle();
    for (int i = 0; i < 1500; i++) begin
      if (!(req0_valid && last_grant != 0)) rand_req(0);
      if (!(req1_valid && last_grant != 1)) rand_req(1);
      if (req0_valid && last_grant == 0) rand_req(0);
      if (req1_valid && last_grant == 1) rand_req(1);
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end
    rst_n = 1;
    req0_valid = 0; req1_valid = 0;
    wait_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
